touch_gesture_sequencer: RTL and testbench



---
 rtl/touch_gesture_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_touch_gesture_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_gesture_sequencer.sv
// ----------------------------------------------------------------------------
// touch_gesture_sequencer
//
// Purpose:
//   Turns the touch-IC sample stream into a validated two-finger
//   "anchor-and-swipe" gesture. Finger 1 stays put (the anchor). Finger 2
//   lands, moves and lifts. One FSM step runs per rising edge of iReady. At
//   the end of a gesture the block emits a single valid or abort pulse, then
//   holds off further gestures for a cooldown period.
//
// Ports:
//   iCLK         in   1  system clock (single clock domain)
//   iRST         in   1  asynchronous, active-high reset
//   iReady       in   1  sample-ready level from the touch IC wrapper
//   iTouchCount  in   4  current finger count
//   iX1/iX2      in  10  x position of finger 1 / finger 2
//   iY1/iY2      in   9  y position of finger 1 / finger 2
//   oX1i/oX2i    out 10  captured initial x of finger 1 / finger 2
//   oY1i/oY2i    out  9  captured initial y of finger 1 / finger 2
//   oX2f         out 10  final x of finger 2 (zero after an abort)
//   oY2f         out  9  final y of finger 2 (zero after an abort)
//   oGestValid   out  1  one-cycle pulse: gesture accepted
//   oGestAbort   out  1  one-cycle pulse: started gesture rejected
//   oBusy        out  1  high in ONE, TWO and COOL
//   oState       out  3  IDLE=0, ONE=1, TWO=2, COOL=3
// ----------------------------------------------------------------------------
module touch_gesture_sequencer #(
  parameter int unsigned TOL          = 10,
  parameter int unsigned MIN_SAMPLES  = 3,
  parameter int unsigned COOLDOWN_CYC = 25_000_000
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iReady,
  input  logic [3:0] iTouchCount,
  input  logic [9:0] iX1,
  input  logic [9:0] iX2,
  input  logic [8:0] iY1,
  input  logic [8:0] iY2,
  output logic [9:0] oX1i,
  output logic [9:0] oX2i,
  output logic [8:0] oY1i,
  output logic [8:0] oY2i,
  output logic [9:0] oX2f,
  output logic [8:0] oY2f,
  output logic       oGestValid,
  output logic       oGestAbort,
  output logic       oBusy,
  output logic [2:0] oState
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ONE  = 3'd1,
    S_TWO  = 3'd2,
    S_COOL = 3'd3
  } state_t;

  localparam logic [31:0] TOL_U      = 32'(TOL);
  localparam logic [31:0] MIN_SAMP_U = 32'(MIN_SAMPLES);
  localparam logic [32:0] COOL_LIM   = 33'(COOLDOWN_CYC);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t      r_state;
  logic        r_ready_q;
  logic        r_armed;
  logic        r_anchor_ok;
  logic [7:0]  r_nsamp;
  logic [9:0]  r_last_x2;
  logic [8:0]  r_last_y2;
  logic [31:0] r_cool_cnt;
  logic [9:0]  r_x1i;
  logic [9:0]  r_x2i;
  logic [8:0]  r_y1i;
  logic [8:0]  r_y2i;
  logic [9:0]  r_x2f;
  logic [8:0]  r_y2f;
  logic        r_valid;
  logic        r_abort;
  logic        r_busy;

  // Next-state values produced by the combinational process
  state_t      w_state_nxt;
  logic        w_anchor_ok_nxt;
  logic [7:0]  w_nsamp_nxt;
  logic [9:0]  w_last_x2_nxt;
  logic [8:0]  w_last_y2_nxt;
  logic [31:0] w_cool_cnt_nxt;
  logic [9:0]  w_x1i_nxt;
  logic [9:0]  w_x2i_nxt;
  logic [8:0]  w_y1i_nxt;
  logic [8:0]  w_y2i_nxt;
  logic [9:0]  w_x2f_nxt;
  logic [8:0]  w_y2f_nxt;
  logic        w_valid_nxt;
  logic        w_abort_nxt;

  // --------------------------------------------------------------------------
  // Sample strobe
  // --------------------------------------------------------------------------
  // r_armed only rises once iReady has been seen low after reset, so a level
  // that is already high when reset releases does not count as a new sample.
  logic w_strobe;
  assign w_strobe = iReady & ~r_ready_q & r_armed;

  // --------------------------------------------------------------------------
  // Finger-count decode
  // --------------------------------------------------------------------------
  logic w_cnt_one;
  logic w_cnt_two;
  assign w_cnt_one = (iTouchCount == 4'd1);
  assign w_cnt_two = (iTouchCount == 4'd2);

  // --------------------------------------------------------------------------
  // Anchor check: true absolute difference, so a far-away finger can never
  // alias into the tolerance window through unsigned wrap-around.
  // --------------------------------------------------------------------------
  logic [9:0] w_dx;
  logic [8:0] w_dy;
  logic       w_anchor_here;
  assign w_dx = (iX1 >= r_x1i) ? (iX1 - r_x1i) : (r_x1i - iX1);
  assign w_dy = (iY1 >= r_y1i) ? (iY1 - r_y1i) : (r_y1i - iY1);
  assign w_anchor_here = ({22'd0, w_dx} <= TOL_U) && ({23'd0, w_dy} <= TOL_U);

  // --------------------------------------------------------------------------
  // Sample counter and cooldown helpers
  // --------------------------------------------------------------------------
  logic [7:0] w_nsamp_inc;
  logic       w_enough;
  logic       w_cool_done;
  assign w_nsamp_inc = (r_nsamp == 8'hFF) ? r_nsamp : (r_nsamp + 8'd1);
  assign w_enough    = ({24'd0, r_nsamp} >= MIN_SAMP_U);
  // Compared as cnt+1 >= limit in 33 bits: equivalent to cnt >= limit-1,
  // with a limit of 0 still giving a single COOL cycle instead of underflow.
  assign w_cool_done = (({1'b0, r_cool_cnt} + 33'd1) >= COOL_LIM);

  // --------------------------------------------------------------------------
  // Next-state / datapath process
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    w_state_nxt     = r_state;
    w_anchor_ok_nxt = r_anchor_ok;
    w_nsamp_nxt     = r_nsamp;
    w_last_x2_nxt   = r_last_x2;
    w_last_y2_nxt   = r_last_y2;
    w_cool_cnt_nxt  = r_cool_cnt;
    w_x1i_nxt       = r_x1i;
    w_x2i_nxt       = r_x2i;
    w_y1i_nxt       = r_y1i;
    w_y2i_nxt       = r_y2i;
    w_x2f_nxt       = r_x2f;
    w_y2f_nxt       = r_y2f;
    w_valid_nxt     = 1'b0;
    w_abort_nxt     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_strobe && w_cnt_one) begin
          w_state_nxt = S_ONE;
        end
      end

      S_ONE: begin
        if (w_strobe) begin
          if (w_cnt_two) begin
            w_state_nxt     = S_TWO;
            w_x1i_nxt       = iX1;
            w_y1i_nxt       = iY1;
            w_x2i_nxt       = iX2;
            w_y2i_nxt       = iY2;
            w_last_x2_nxt   = iX2;
            w_last_y2_nxt   = iY2;
            w_nsamp_nxt     = 8'd0;
            w_anchor_ok_nxt = 1'b1;
          end else if (!w_cnt_one) begin
            // Finger lifted or a crowd landed before the gesture started.
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_TWO: begin
        if (w_strobe) begin
          if (w_cnt_two) begin
            // Once the anchor has drifted the gesture can no longer pass.
            if (!w_anchor_here) begin
              w_anchor_ok_nxt = 1'b0;
            end
            w_nsamp_nxt   = w_nsamp_inc;
            w_last_x2_nxt = iX2;
            w_last_y2_nxt = iY2;
          end else if (w_cnt_one) begin
            // Finger 2 lifted: the gesture ends here either way.
            w_state_nxt    = S_COOL;
            w_cool_cnt_nxt = 32'd0;
            if (r_anchor_ok && w_enough) begin
              w_x2f_nxt   = r_last_x2;
              w_y2f_nxt   = r_last_y2;
              w_valid_nxt = 1'b1;
            end else begin
              w_x2f_nxt   = 10'd0;
              w_y2f_nxt   = 9'd0;
              w_abort_nxt = 1'b1;
            end
          end else begin
            // All fingers gone or a third finger: abort with no cooldown.
            w_state_nxt = S_IDLE;
            w_x2f_nxt   = 10'd0;
            w_y2f_nxt   = 9'd0;
            w_abort_nxt = 1'b1;
          end
        end
      end

      S_COOL: begin
        // Runs every cycle; strobes are deliberately ignored here.
        w_cool_cnt_nxt = r_cool_cnt + 32'd1;
        if (w_cool_done) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: non-blocking assignments so every register samples the values from
  // before this edge, regardless of statement order.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state     <= S_IDLE;
      r_ready_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_anchor_ok <= 1'b0;
      r_nsamp     <= 8'd0;
      r_last_x2   <= 10'd0;
      r_last_y2   <= 9'd0;
      r_cool_cnt  <= 32'd0;
      r_x1i       <= 10'd0;
      r_x2i       <= 10'd0;
      r_y1i       <= 9'd0;
      r_y2i       <= 9'd0;
      r_x2f       <= 10'd0;
      r_y2f       <= 9'd0;
      r_valid     <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_ready_q   <= iReady;
      r_armed     <= r_armed | ~iReady;
      r_state     <= w_state_nxt;
      r_anchor_ok <= w_anchor_ok_nxt;
      r_nsamp     <= w_nsamp_nxt;
      r_last_x2   <= w_last_x2_nxt;
      r_last_y2   <= w_last_y2_nxt;
      r_cool_cnt  <= w_cool_cnt_nxt;
      r_x1i       <= w_x1i_nxt;
      r_x2i       <= w_x2i_nxt;
      r_y1i       <= w_y1i_nxt;
      r_y2i       <= w_y2i_nxt;
      r_x2f       <= w_x2f_nxt;
      r_y2f       <= w_y2f_nxt;
      r_valid     <= w_valid_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // --------------------------------------------------------------------------
  assign oX1i       = r_x1i;
  assign oX2i       = r_x2i;
  assign oY1i       = r_y1i;
  assign oY2i       = r_y2i;
  assign oX2f       = r_x2f;
  assign oY2f       = r_y2f;
  assign oGestValid = r_valid;
  assign oGestAbort = r_abort;
  assign oBusy      = r_busy;
  assign oState     = r_state;

endmodule

// File: tb/tb_touch_gesture_sequencer.sv
// ----------------------------------------------------------------------------
// tb_touch_gesture_sequencer
//
// Table of strobe steps with hand-computed expected outputs, plus hand-written
// sequences for cooldown length, a level-held iReady, and reset mid-gesture.
// A second instance with COOLDOWN_CYC=0 shares all inputs so its one-cycle
// COOL can be observed alongside the main instance.
// ----------------------------------------------------------------------------
module tb_touch_gesture_sequencer;

  localparam int unsigned CD = 5;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ONE  = 3'd1;
  localparam logic [2:0] ST_TWO  = 3'd2;
  localparam logic [2:0] ST_COOL = 3'd3;

  logic       iCLK = 1'b0;
  logic       iRST;
  logic       iReady;
  logic [3:0] iTouchCount;
  logic [9:0] iX1, iX2;
  logic [8:0] iY1, iY2;

  logic [9:0] m_x1i, m_x2i, m_x2f;
  logic [8:0] m_y1i, m_y2i, m_y2f;
  logic       m_valid, m_abort, m_busy;
  logic [2:0] m_state;

  logic [9:0] z_x1i, z_x2i, z_x2f;
  logic [8:0] z_y1i, z_y2i, z_y2f;
  logic       z_valid, z_abort, z_busy;
  logic [2:0] z_state;

  int total = 0;
  int bad   = 0;

  always #5 iCLK = ~iCLK;

  touch_gesture_sequencer #(.TOL(10), .MIN_SAMPLES(3), .COOLDOWN_CYC(CD)) dut (
    .iCLK(iCLK), .iRST(iRST), .iReady(iReady), .iTouchCount(iTouchCount),
    .iX1(iX1), .iX2(iX2), .iY1(iY1), .iY2(iY2),
    .oX1i(m_x1i), .oX2i(m_x2i), .oY1i(m_y1i), .oY2i(m_y2i),
    .oX2f(m_x2f), .oY2f(m_y2f), .oGestValid(m_valid), .oGestAbort(m_abort),
    .oBusy(m_busy), .oState(m_state)
  );

  touch_gesture_sequencer #(.TOL(10), .MIN_SAMPLES(3), .COOLDOWN_CYC(0)) dut_z (
    .iCLK(iCLK), .iRST(iRST), .iReady(iReady), .iTouchCount(iTouchCount),
    .iX1(iX1), .iX2(iX2), .iY1(iY1), .iY2(iY2),
    .oX1i(z_x1i), .oX2i(z_x2i), .oY1i(z_y1i), .oY2i(z_y2i),
    .oX2f(z_x2f), .oY2f(z_y2f), .oGestValid(z_valid), .oGestAbort(z_abort),
    .oBusy(z_busy), .oState(z_state)
  );

  typedef struct {
    logic [3:0] cnt;
    logic [9:0] x1;
    logic [8:0] y1;
    logic [9:0] x2;
    logic [8:0] y2;
    logic [2:0] st;
    logic       v;
    logic       a;
    logic [9:0] x2f;
    logic [8:0] y2f;
    logic [9:0] x1i;
    logic [8:0] y1i;
    logic [9:0] x2i;
    logic [8:0] y2i;
  } vec_t;

  vec_t tbl[$];

  logic [9:0] e_x1i = '0;
  logic [8:0] e_y1i = '0;
  logic [9:0] e_x2i = '0;
  logic [8:0] e_y2i = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ini(input logic [9:0] x1i, input logic [8:0] y1i,
                         input logic [9:0] x2i, input logic [8:0] y2i);
    e_x1i = x1i; e_y1i = y1i; e_x2i = x2i; e_y2i = y2i;
  endtask

  task automatic row(input logic [3:0] cnt,
                     input logic [9:0] x1, input logic [8:0] y1,
                     input logic [9:0] x2, input logic [8:0] y2,
                     input logic [2:0] st, input logic v, input logic a,
                     input logic [9:0] x2f, input logic [8:0] y2f);
    vec_t r;
    r.cnt = cnt; r.x1 = x1; r.y1 = y1; r.x2 = x2; r.y2 = y2;
    r.st = st; r.v = v; r.a = a; r.x2f = x2f; r.y2f = y2f;
    r.x1i = e_x1i; r.y1i = e_y1i; r.x2i = e_x2i; r.y2i = e_y2i;
    tbl.push_back(r);
  endtask

  // One iReady pulse (one cycle high after one cycle low). Returns #1 after
  // the strobe edge, i.e. in the cycle where the step's effects are visible.
  task automatic step(input logic [3:0] cnt,
                      input logic [9:0] x1, input logic [8:0] y1,
                      input logic [9:0] x2, input logic [8:0] y2);
    @(negedge iCLK);
    iReady = 1'b0;
    @(negedge iCLK);
    iTouchCount = cnt; iX1 = x1; iY1 = y1; iX2 = x2; iY2 = y2;
    iReady = 1'b1;
    @(posedge iCLK);
    #1;
  endtask

  // Called in the first COOL cycle; measures how long COOL lasts.
  task automatic wait_cool(input int idx);
    int n;
    n = 0;
    check($sformatf("row%0d zero-cooldown entered", idx), 32'(z_state), 32'(ST_COOL));
    while (m_state == ST_COOL && n < 100) begin
      n++;
      @(posedge iCLK);
      #1;
      if (n == 1) begin
        check($sformatf("row%0d zero-cooldown left", idx), 32'(z_state), 32'(ST_IDLE));
        check($sformatf("row%0d valid one cycle", idx), 32'(m_valid), 32'd0);
        check($sformatf("row%0d abort one cycle", idx), 32'(m_abort), 32'd0);
      end
    end
    check($sformatf("row%0d cool length", idx), 32'(n), 32'(CD));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " state"}, 32'(m_state), 32'd0);
    check({tag, " busy"},  32'(m_busy),  32'd0);
    check({tag, " valid"}, 32'(m_valid), 32'd0);
    check({tag, " abort"}, 32'(m_abort), 32'd0);
    check({tag, " x1i"},   32'(m_x1i),   32'd0);
    check({tag, " y1i"},   32'(m_y1i),   32'd0);
    check({tag, " x2i"},   32'(m_x2i),   32'd0);
    check({tag, " y2i"},   32'(m_y2i),   32'd0);
    check({tag, " x2f"},   32'(m_x2f),   32'd0);
    check({tag, " y2f"},   32'(m_y2f),   32'd0);
  endtask

  initial begin
    iRST = 1'b1; iReady = 1'b0; iTouchCount = '0;
    iX1 = '0; iY1 = '0; iX2 = '0; iY2 = '0;

    // ---- vector table ----
    // Valid gesture; anchor diffs of exactly 10 on x and y stay inside TOL.
    set_ini(0, 0, 0, 0);
    row(1,   0,   0,   0,   0, ST_ONE,  0, 0,   0,   0);
    set_ini(100, 100, 300, 200);
    row(2, 100, 100, 300, 200, ST_TWO,  0, 0,   0,   0);
    row(2,  90, 100, 350, 220, ST_TWO,  0, 0,   0,   0);
    row(2, 104, 110, 380, 240, ST_TWO,  0, 0,   0,   0);
    row(2, 108, 100, 400, 250, ST_TWO,  0, 0,   0,   0);
    row(1, 108, 100,   0,   0, ST_COOL, 1, 0, 400, 250);
    // Third finger during TWO: abort, straight to IDLE, final point cleared.
    row(1, 200, 100,   0,   0, ST_ONE,  0, 0, 400, 250);
    set_ini(200, 100, 250, 150);
    row(2, 200, 100, 250, 150, ST_TWO,  0, 0, 400, 250);
    row(2, 201, 100, 260, 150, ST_TWO,  0, 0, 400, 250);
    row(3, 201, 100, 260, 150, ST_IDLE, 0, 1,   0,   0);
    // IDLE ignores count 2 / 3; ONE drops back on count 0.
    row(2,   1,   1,   1,   1, ST_IDLE, 0, 0,   0,   0);
    row(3,   1,   1,   1,   1, ST_IDLE, 0, 0,   0,   0);
    row(1,   1,   1,   0,   0, ST_ONE,  0, 0,   0,   0);
    row(0,   0,   0,   0,   0, ST_IDLE, 0, 0,   0,   0);
    // Anchor drift of 11 on one sample.
    row(1, 100, 100,   0,   0, ST_ONE,  0, 0,   0,   0);
    set_ini(100, 100, 300, 200);
    row(2, 100, 100, 300, 200, ST_TWO,  0, 0,   0,   0);
    row(2, 111, 100, 310, 200, ST_TWO,  0, 0,   0,   0);
    row(2, 100, 100, 320, 200, ST_TWO,  0, 0,   0,   0);
    row(2, 100, 100, 330, 200, ST_TWO,  0, 0,   0,   0);
    row(1, 100, 100,   0,   0, ST_COOL, 0, 1,   0,   0);
    // Too few samples (2 after capture).
    row(1,  50,  60,   0,   0, ST_ONE,  0, 0,   0,   0);
    set_ini(50, 60, 70, 80);
    row(2,  50,  60,  70,  80, ST_TWO,  0, 0,   0,   0);
    row(2,  50,  60,  71,  81, ST_TWO,  0, 0,   0,   0);
    row(2,  50,  60,  72,  82, ST_TWO,  0, 0,   0,   0);
    row(1,  50,  60,   0,   0, ST_COOL, 0, 1,   0,   0);
    // No wrap: |5-1020| = 1015, while a 10-bit wrap would give 9.
    row(1,   5, 100,   0,   0, ST_ONE,  0, 0,   0,   0);
    set_ini(5, 100, 300, 200);
    row(2,   5, 100, 300, 200, ST_TWO,  0, 0,   0,   0);
    row(2, 1020, 100, 301, 200, ST_TWO, 0, 0,   0,   0);
    row(2,   5, 100, 302, 200, ST_TWO,  0, 0,   0,   0);
    row(2,   5, 100, 303, 200, ST_TWO,  0, 0,   0,   0);
    row(1,   5, 100,   0,   0, ST_COOL, 0, 1,   0,   0);
    // ONE holds on repeated count 1, then a second valid gesture.
    row(1,  10,  20,   0,   0, ST_ONE,  0, 0,   0,   0);
    row(1,  10,  20,   0,   0, ST_ONE,  0, 0,   0,   0);
    set_ini(10, 20, 30, 40);
    row(2,  10,  20,  30,  40, ST_TWO,  0, 0,   0,   0);
    row(2,  10,  20,  31,  41, ST_TWO,  0, 0,   0,   0);
    row(2,  10,  20,  32,  42, ST_TWO,  0, 0,   0,   0);
    row(2,  10,  20,  33,  43, ST_TWO,  0, 0,   0,   0);
    row(1,  10,  20,   0,   0, ST_COOL, 1, 0,  33,  43);

    // ---- reset state ----
    repeat (3) @(posedge iCLK);
    #1;
    check_all_zero("reset");
    @(negedge iCLK);
    iRST = 1'b0;

    // ---- table ----
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].cnt, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2);
      check($sformatf("row%0d state", i), 32'(m_state), 32'(tbl[i].st));
      check($sformatf("row%0d busy", i),  32'(m_busy),  32'(tbl[i].st != ST_IDLE));
      check($sformatf("row%0d valid", i), 32'(m_valid), 32'(tbl[i].v));
      check($sformatf("row%0d abort", i), 32'(m_abort), 32'(tbl[i].a));
      check($sformatf("row%0d x2f", i),   32'(m_x2f),   32'(tbl[i].x2f));
      check($sformatf("row%0d y2f", i),   32'(m_y2f),   32'(tbl[i].y2f));
      check($sformatf("row%0d x1i", i),   32'(m_x1i),   32'(tbl[i].x1i));
      check($sformatf("row%0d y1i", i),   32'(m_y1i),   32'(tbl[i].y1i));
      check($sformatf("row%0d x2i", i),   32'(m_x2i),   32'(tbl[i].x2i));
      check($sformatf("row%0d y2i", i),   32'(m_y2i),   32'(tbl[i].y2i));
      if (tbl[i].st == ST_COOL) wait_cool(i);
    end

    // ---- level iReady: one step for a 1000-cycle high period ----
    @(negedge iCLK);
    iReady = 1'b0;
    @(negedge iCLK);
    iTouchCount = 4'd1;
    iReady = 1'b1;
    @(posedge iCLK);
    #1;
    check("level first step", 32'(m_state), 32'(ST_ONE));
    repeat (5) @(posedge iCLK);
    @(negedge iCLK);
    iTouchCount = 4'd2;
    iX1 = 10'd123; iY1 = 9'd45; iX2 = 10'd67; iY2 = 9'd89;
    repeat (995) @(posedge iCLK);
    #1;
    check("level no second step", 32'(m_state), 32'(ST_ONE));
    check("level no capture x1i", 32'(m_x1i), 32'd10);
    step(0, 0, 0, 0, 0);
    check("level next pulse steps", 32'(m_state), 32'(ST_IDLE));

    // ---- reset during TWO, with iReady held high across reset release ----
    step(1, 7, 8, 0, 0);
    step(2, 7, 8, 9, 10);
    check("pre-reset state", 32'(m_state), 32'(ST_TWO));
    check("pre-reset x2i", 32'(m_x2i), 32'd9);
    @(negedge iCLK);
    iTouchCount = 4'd1;
    #2;
    iRST = 1'b1;
    #1;
    check_all_zero("mid-gesture reset");
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (4) @(posedge iCLK);
    #1;
    check("held ready after reset no step", 32'(m_state), 32'(ST_IDLE));
    check("held ready after reset no pulse", 32'(m_abort | m_valid), 32'd0);
    step(1, 0, 0, 0, 0);
    check("fresh rise after reset steps", 32'(m_state), 32'(ST_ONE));
    step(0, 0, 0, 0, 0);
    check("back to idle", 32'(m_state), 32'(ST_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
